// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: stalls ID on RAW hazards and on WAW hazards that
// would let a shorter producer overtake a pending longer one. Supports early completion and EX kill.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_LAT  = 15,
  parameter int FWD_EN   = 1,
  parameter int WB_DIST  = 3,
  parameter int PERF_W   = 32,
  localparam int CNT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1_addr,
  input  logic              id_rs1_used,
  input  logic [ADDR_W-1:0] id_rs2_addr,
  input  logic              id_rs2_used,
  input  logic [ADDR_W-1:0] id_rd_addr,
  input  logic              id_wb_en,
  input  logic [CNT_W-1:0]  id_lat,
  input  logic              kill_valid,
  input  logic [ADDR_W-1:0] kill_rd,
  input  logic              cmpl_valid,
  input  logic [ADDR_W-1:0] cmpl_rd,
  output logic              stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
  logic [31:0]      eff_lat;
  logic [CNT_W-1:0] lat_sat;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             waw_hit;
  logic             issue;

  // eff_lat is kept wide so the WAW compare sees the unsaturated latency
  always_comb begin
    eff_lat = 32'(id_lat) + ((FWD_EN != 0) ? 32'd0 : 32'(WB_DIST));
    lat_sat = (eff_lat > 32'(CNT_MAX)) ? CNT_MAX : eff_lat[CNT_W-1:0];
  end

  always_comb begin
    rs1_hit = id_rs1_used && (id_rs1_addr != '0) && (cnt[id_rs1_addr] != '0);
    rs2_hit = id_rs2_used && (id_rs2_addr != '0) && (cnt[id_rs2_addr] != '0);
    waw_hit = id_wb_en && (id_rd_addr != '0) && (32'(cnt[id_rd_addr]) > eff_lat);
    stall   = id_valid && !kill_valid && (rs1_hit || rs2_hit || waw_hit);
    issue   = id_valid && !stall && !kill_valid && id_wb_en && (id_rd_addr != '0);
  end

  always_comb begin
    cnt_nxt[0] = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (issue && (id_rd_addr == ADDR_W'(i)))
        cnt_nxt[i] = lat_sat;
      else if (kill_valid && (kill_rd == ADDR_W'(i)))
        cnt_nxt[i] = '0;
      else if (cmpl_valid && (cmpl_rd == ADDR_W'(i)))
        cnt_nxt[i] = '0;
      else if (cnt[i] != '0)
        cnt_nxt[i] = cnt[i] - 1'b1;
      else
        cnt_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      stall_cycles <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_nxt[i];
      if (stall) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) busy_mask[i] = (cnt[i] != '0);
  end

endmodule
